// File: rtl/case_1_sdiv_26s_12s_26_seq.sv
// Sequential signed divider (26s / 12s): restoring radix-2 on magnitudes, start/done handshake.
// Optional divide-by-zero detection and port enabled by defining CASE_1_SDIV_DIV0_EN.
module case_1_sdiv_26s_12s_26_seq #(
  parameter int ID         = 1,
  parameter int din0_WIDTH = 26,
  parameter int din1_WIDTH = 12,
  parameter int quot_WIDTH = 26,
  parameter int rem_WIDTH  = 12
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  start,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  ready,
  output logic                  done,
  output logic [quot_WIDTH-1:0] dout_quot,
  output logic [rem_WIDTH-1:0]  dout_rem
`ifdef CASE_1_SDIV_DIV0_EN
  ,
  output logic                  div_by_zero
`endif
);

  localparam int PW = din1_WIDTH + 1;
  localparam int TW = din1_WIDTH + 2;
  localparam int CW = $clog2(din0_WIDTH);

  // ID is informational only; widths must pair up with the operands.
  if ((quot_WIDTH != din0_WIDTH) || (rem_WIDTH != din1_WIDTH) || (ID < 0)) begin : g_cfg_check
    $error("case_1_sdiv_26s_12s_26_seq: invalid parameter combination");
  end

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIN
  } state_t;

  state_t state, state_nxt;

  logic [din0_WIDTH-1:0] dvd;   // dividend magnitude, shifted out MSB-first while quotient bits shift in
  logic [din1_WIDTH-1:0] dsr;
  logic [PW-1:0]         prem;
  logic [CW-1:0]         cnt;
  logic                  sign_q;
  logic                  sign_r;
  logic                  last_iter;
  logic                  fit;
  logic [TW-1:0]         trial;
  logic [din1_WIDTH-1:0] rmag;
`ifdef CASE_1_SDIV_DIV0_EN
  logic [rem_WIDTH-1:0]  dvd_lo;
`endif

  assign ready = (state == IDLE);

  always_comb begin
    last_iter = (cnt == CW'(din0_WIDTH - 1));
    trial     = {prem, dvd[din0_WIDTH-1]};
    fit       = (trial >= TW'(dsr));
    rmag      = prem[din1_WIDTH-1:0];
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (last_iter) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      dvd       <= '0;
      dsr       <= '0;
      prem      <= '0;
      cnt       <= '0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
      done      <= 1'b0;
      dout_quot <= '0;
      dout_rem  <= '0;
`ifdef CASE_1_SDIV_DIV0_EN
      dvd_lo      <= '0;
      div_by_zero <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            dvd    <= din0[din0_WIDTH-1] ? -din0 : din0;
            dsr    <= din1[din1_WIDTH-1] ? -din1 : din1;
            sign_q <= din0[din0_WIDTH-1] ^ din1[din1_WIDTH-1];
            sign_r <= din0[din0_WIDTH-1];
            prem   <= '0;
            cnt    <= '0;
`ifdef CASE_1_SDIV_DIV0_EN
            dvd_lo      <= din0[rem_WIDTH-1:0];
            div_by_zero <= 1'b0;
`endif
          end
        end
        CALC: begin
          prem <= PW'(fit ? trial - TW'(dsr) : trial);
          dvd  <= {dvd[din0_WIDTH-2:0], fit};
          cnt  <= cnt + CW'(1);
        end
        FIN: begin
          done      <= 1'b1;
          dout_quot <= sign_q ? -dvd : dvd;
          dout_rem  <= sign_r ? -rmag : rmag;
`ifdef CASE_1_SDIV_DIV0_EN
          if (dsr == '0) begin
            dout_quot   <= '1;
            dout_rem    <= dvd_lo;
            div_by_zero <= 1'b1;
          end
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_case_1_sdiv_26s_12s_26_seq.sv
// Self-checking bench for case_1_sdiv_26s_12s_26_seq against a C-semantics divide model.
module tb_case_1_sdiv_26s_12s_26_seq;

  logic        ap_clk;
  logic        ap_rst_n;
  logic        start;
  logic [25:0] din0;
  logic [11:0] din1;
  logic        ready;
  logic        done;
  logic [25:0] dout_quot;
  logic [11:0] dout_rem;
`ifdef CASE_1_SDIV_DIV0_EN
  logic        div_by_zero;
`endif

  int n_cmp = 0;
  int n_err = 0;

  case_1_sdiv_26s_12s_26_seq #(
    .ID(1),
    .din0_WIDTH(26),
    .din1_WIDTH(12),
    .quot_WIDTH(26),
    .rem_WIDTH(12)
  ) dut (
    .ap_clk(ap_clk),
    .ap_rst_n(ap_rst_n),
    .start(start),
    .din0(din0),
    .din1(din1),
    .ready(ready),
    .done(done),
    .dout_quot(dout_quot),
    .dout_rem(dout_rem)
`ifdef CASE_1_SDIV_DIV0_EN
    ,
    .div_by_zero(div_by_zero)
`endif
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // C semantics: quotient truncates toward zero, remainder follows the dividend.
  function automatic void model(input logic [25:0] a, input logic [11:0] b,
                                output logic [25:0] q, output logic [11:0] r);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sb == 0) begin
      q = '1;
      r = a[11:0];
    end else begin
      q = 26'(sa / sb);
      r = 12'(sa % sb);
    end
  endfunction

  task automatic wait_ready();
    int k;
    k = 0;
    @(negedge ap_clk);
    while (!ready && k < 100) begin
      @(negedge ap_clk);
      k++;
    end
    if (!ready) check("ready_timeout", 32'(ready), 32'd1);
  endtask

  task automatic do_op(input logic [25:0] a, input logic [11:0] b, input string tag);
    int  n;
    bit  seen;
    bit  rdy_bad;
    logic [25:0] eq;
    logic [11:0] er;
    wait_ready();
    din0  = a;
    din1  = b;
    start = 1'b1;
    @(posedge ap_clk);
    #1;
    start = 1'b0;
    din0  = 26'($urandom);
    din1  = 12'($urandom);
    n = 0;
    seen = 1'b0;
    rdy_bad = 1'b0;
    while (!seen && n < 40) begin
      @(posedge ap_clk);
      n++;
      #1;
      if (done) seen = 1'b1;
      else if (ready) rdy_bad = 1'b1;
      // a stray request mid-calculation must be ignored
      start = (n == 5);
      if (n == 5) begin
        din0 = 26'($urandom);
        din1 = 12'($urandom);
      end
    end
    start = 1'b0;
    model(a, b, eq, er);
    check({tag, "_latency"}, 32'(n), 32'd27);
    check({tag, "_ready_low"}, 32'(rdy_bad), 32'd0);
    check({tag, "_quot"}, 32'(dout_quot), 32'(eq));
    check({tag, "_rem"}, 32'(dout_rem), 32'(er));
`ifdef CASE_1_SDIV_DIV0_EN
    check({tag, "_div0"}, 32'(div_by_zero), 32'(b == 12'd0));
`endif
    @(posedge ap_clk);
    #1;
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  logic [25:0] ha [4];
  logic [11:0] hb [4];

  initial begin : main
    int t;
    int k;
    int ndone;
    logic [25:0] a, eq;
    logic [11:0] b, er;

    ap_rst_n = 1'b0;
    start    = 1'b0;
    din0     = '0;
    din1     = '0;
    repeat (3) @(negedge ap_clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_quot", 32'(dout_quot), 32'd0);
    check("rst_rem", 32'(dout_rem), 32'd0);
`ifdef CASE_1_SDIV_DIV0_EN
    check("rst_div0", 32'(div_by_zero), 32'd0);
`endif
    ap_rst_n = 1'b1;

    do_op(26'd1000, 12'd7, "pp");
    do_op(26'(-1000), 12'd7, "np");
    do_op(26'd1000, 12'(-7), "pn");
    do_op(26'(-1000), 12'(-7), "nn");
    do_op(26'(-33554432), 12'(-1), "ovf");
    do_op(26'd33554431, 12'(-2048), "maxdiv");
    do_op(26'd0, 12'd5, "zero_dvd");

    for (int i = 0; i < 30; i++) begin
      a = 26'($urandom);
      if (i % 3 == 0) b = 12'($urandom_range(1, 15)) * (($urandom & 1) != 0 ? 12'hFFF : 12'd1);
      else b = 12'($urandom);
      if (b == 12'd0) b = 12'd1;
      do_op(a, b, "rand");
    end

    // start held high: one accept per done cycle, operands swapped mid-calculation
    ha[0] = 26'd123456;   hb[0] = 12'd13;
    ha[1] = 26'(-98765);  hb[1] = 12'd100;
    ha[2] = 26'd777;      hb[2] = 12'(-3);
    ha[3] = 26'd55;       hb[3] = 12'd11;
    wait_ready();
    din0  = ha[0];
    din1  = hb[0];
    start = 1'b1;
    @(posedge ap_clk);
    #1;
    din0 = ha[1];
    din1 = hb[1];
    t = 0;
    k = 0;
    while (k < 3 && t < 200) begin
      @(posedge ap_clk);
      t++;
      #1;
      if (done) begin
        model(ha[k], hb[k], eq, er);
        check("hold_time", 32'(t), 32'(27 + 28 * k));
        check("hold_quot", 32'(dout_quot), 32'(eq));
        check("hold_rem", 32'(dout_rem), 32'(er));
        k++;
        if (k == 3) begin
          start = 1'b0;
        end else begin
          @(posedge ap_clk);
          t++;
          #1;
          din0 = ha[k + 1];
          din1 = hb[k + 1];
        end
      end
    end
    start = 1'b0;
    check("hold_count", 32'(k), 32'd3);

    // asynchronous abort ten cycles into an operation
    do_op(26'd1000, 12'd7, "pre_abort");
    wait_ready();
    din0  = 26'd4000;
    din1  = 12'd9;
    start = 1'b1;
    @(posedge ap_clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b0;
    #1;
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_done", 32'(done), 32'd0);
    check("abort_quot", 32'(dout_quot), 32'd0);
    check("abort_rem", 32'(dout_rem), 32'd0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge ap_clk);
      if (done) ndone++;
    end
    check("abort_no_done", 32'(ndone), 32'd0);
    do_op(26'd1000, 12'd7, "post_abort");

`ifdef CASE_1_SDIV_DIV0_EN
    do_op(26'd5, 12'd0, "div0");
    do_op(26'd9, 12'd3, "after_div0");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/case_1_sdiv_26s_12s_26_seq.md
Name: case_1_sdiv_26s_12s_26_seq

Overview:
- Sequential signed integer divider and remainder unit. It is the inverse operator of the combinational 14s x 12s -> 26 signed multiplier core.
- Takes a 26-bit signed dividend (product width) and a 12-bit signed divisor, and returns quotient and remainder with C semantics.
- Instantiated by the HLS datapath as a multi-cycle functional unit with a start/done handshake.
- Implementation: radix-2 restoring division on operand magnitudes, one quotient bit per cycle.

Parameters:
- ID, 1, instance identifier; no functional effect.
- din0_WIDTH, 26, dividend width (signed).
- din1_WIDTH, 12, divisor width (signed).
- quot_WIDTH, 26, quotient width; must equal din0_WIDTH.
- rem_WIDTH, 12, remainder width; must equal din1_WIDTH.

Ports:
- ap_clk  in  1  clock; all state changes on rising edge.
- ap_rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only while ready=1.
- din0  in  din0_WIDTH  signed dividend; sampled at the accepting edge.
- din1  in  din1_WIDTH  signed divisor; sampled at the accepting edge.
- ready  out  1  high when the unit can accept start (state IDLE).
- done  out  1  one-cycle pulse; dout_quot/dout_rem valid in that cycle.
- dout_quot  out  quot_WIDTH  signed quotient; holds until next done.
- dout_rem  out  rem_WIDTH  signed remainder; holds until next done.
- div_by_zero  out  1  present only with the optional feature; valid with done.

Behaviour:
- Reset (ap_rst_n=0, asynchronous): state IDLE; ready=1; done=0; dout_quot=0; dout_rem=0; div_by_zero=0; iteration counter=0.
- Reset mid-operation aborts immediately. No done is produced for the aborted operation.
- States: IDLE, CALC, FIN.
- IDLE:
  - ready=1.
  - On an edge with start=1, latch |din0| and |din1| (unsigned, din0_WIDTH and din1_WIDTH bits).
  - Latch sign_q = din0[MSB]^din1[MSB] and sign_r = din0[MSB].
  - Clear the partial remainder (din1_WIDTH+1 bits) and counter; go to CALC.
- CALC:
  - ready=0.
  - Each edge: shift the next dividend MSB into the partial remainder, then trial-subtract |divisor|.
  - If the result is non-negative, keep the difference and shift in quotient bit 1; otherwise restore and shift in 0.
  - After din0_WIDTH iterations (counter = din0_WIDTH-1 at that edge), go to FIN.
- FIN:
  - ready=0.
  - On the next edge register dout_quot = sign_q ? -qmag : qmag and dout_rem = sign_r ? -rmag : rmag, both two's complement and truncated to the port width.
  - Assert done for exactly the following cycle; return to IDLE.
- Latency: start accepted at edge E0 gives done=1 in the cycle after edge E0+din0_WIDTH+1, which is 27 edges at defaults. Throughput is one operation per 28 cycles.
- Back-to-back: state is IDLE and ready=1 during the done cycle, so start may be accepted in that same cycle.
- start while ready=0 is ignored; it is not queued and the in-flight operation is unaffected.
- din0/din1 changes after the accepting edge have no effect.
- Arithmetic semantics:
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
  - |rem| < |divisor|.
- Overflow: -2^25 / -1 wraps to -2^25 (0x2000000) with remainder 0; no flag.
- Divisor -2048 and remainder magnitudes up to 2047 fit rem_WIDTH; no special case.
- Internal magnitude registers are unsigned and one bit wider where needed, so |-2^25| and |-2048| are represented exactly.

Optional Feature:
- Macro: CASE_1_SDIV_DIV0_EN.
- Defined:
  - Port div_by_zero exists.
  - If the latched divisor is 0, the result at the FIN edge is forced: dout_quot = all ones (-1), dout_rem = din0[rem_WIDTH-1:0], div_by_zero=1 with done.
  - Latency is unchanged.
  - div_by_zero is cleared on the next accepted start and on reset.
- Not defined:
  - Port and detection logic are absent.
  - Divide-by-zero results are unspecified and not checked.

Test Plan:
- Reset release, then din0=1000, din1=7, start pulse -> done exactly 27 edges after acceptance; quot=142, rem=6; ready=0 in between.
- Sign combinations:
  - -1000/7 -> quot=-142, rem=-6.
  - 1000/-7 -> quot=-142, rem=6.
  - -1000/-7 -> quot=142, rem=-6.
- Boundaries:
  - -33554432/-1 -> quot=-33554432, rem=0.
  - 33554431/-2048 -> quot=-16383, rem=2047.
  - 0/5 -> quot=0, rem=0.
- Handshake: start held high continuously -> operations accepted in each done cycle (period 28). start pulses during CALC are ignored and results match only the accepted operands.
- Deassert ap_rst_n 10 cycles into an operation -> outputs 0 and ready=1 immediately, no done; a new 1000/7 then completes normally.
- With CASE_1_SDIV_DIV0_EN, 5/0 -> done at normal latency, div_by_zero=1, quot=-1, rem=5; next op 9/3 -> div_by_zero=0, quot=3, rem=0.
